// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and constants for the push-button conditioning logic.
//   btn_state_t  : debounce FSM state encoding
//   PRESS_CNT_W  : width of the accepted-press counter
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        FIRE   = 3'd2,
        HELD   = 3'd3,
        DISARM = 3'd4
    } btn_state_t;

    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// N-flop synchroniser for an asynchronous input. Reusable for any board input.
// Ports:
//   clk_i   in  1  destination clock
//   rst_ni  in  1  asynchronous active-low reset; all flops load RESET_VAL
//   d_i     in  1  asynchronous input
//   q_o     out 1  synchronised output (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be >= 2");
    end

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/go_button_conditioner.sv
// -----------------------------------------------------------------------------
// go_button_conditioner
// Turns a raw, bouncing, asynchronous push-button into a single-cycle 'go'
// strobe for the colour write-enable FSM, plus a debounced level and a press
// counter for LEDs/debug.
// Ports:
//   clk          in   1  system clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   btn_raw      in   1  raw pin, asynchronous and bouncing
//   go           out  1  one-cycle pulse per accepted press
//   btn_level    out  1  debounced level, 1 = pressed
//   press_count  out  8  accepted presses, modulo 256
//   dbg_state    out  3  current debounce FSM state (btn_state_t encoding)
// Handshake: none. go is a plain strobe; the consumer must act on every cycle
// in which it is high, and it is never high on two consecutive cycles.
// -----------------------------------------------------------------------------
module go_button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   btn_raw,
    output logic                   go,
    output logic                   btn_level,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic [2:0]             dbg_state
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("go_button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("go_button_conditioner: SYNC_STAGES must be >= 2");
    end

    localparam int         CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Pin level that means "not pressed"; the synchroniser resets to it so a
    // reset never looks like a press edge.
    localparam logic       PIN_IDLE = (BTN_ACTIVE_LOW != 0);

    logic sync_out;
    logic btn_s;

    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (btn_raw),
        .q_o    (sync_out)
    );

    // Normalise polarity: btn_s = 1 means pressed.
    assign btn_s = sync_out ^ PIN_IDLE;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_count_d = press_count_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_s) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!btn_s) begin
                    // Press bounce: start over, no pulse.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIRE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIRE: begin
                // Pin is deliberately not looked at here; HELD picks it up.
                press_count_d = press_count_q + 1'b1;
                cnt_d         = '0;
                state_d       = HELD;
            end
            HELD: begin
                cnt_d = '0;
                if (!btn_s) begin
                    state_d = DISARM;
                end
            end
            DISARM: begin
                if (btn_s) begin
                    // Release bounce: still held, no new pulse possible.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_count_q <= press_count_d;
        end
    end

    // Outputs decode the state register only, so nothing from btn_raw can
    // reach them combinationally.
    assign go          = (state_q == FIRE);
    assign btn_level   = (state_q == FIRE) || (state_q == HELD) || (state_q == DISARM);
    assign press_count = press_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_go_button_conditioner.sv
module tb_go_button_conditioner;
    import button_pkg::*;

    localparam int D       = 4;
    localparam int SYNC    = 2;
    localparam int ALOW    = 1;
    localparam int GAP_MIN = 2 * D + 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_raw;
    logic       go;
    logic       btn_level;
    logic [7:0] press_count;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    go_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (SYNC),
        .BTN_ACTIVE_LOW  (ALOW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .go          (go),
        .btn_level   (btn_level),
        .press_count (press_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int last_go = -1;
    int go_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Pin samples reach the debouncer SYNC edges late (a plain delay queue).
    // The debounced level flips once D+1 consecutive samples disagree with it;
    // a flip to "pressed" emits go for one cycle, during which the sample is
    // discarded, and the press is counted when that cycle ends.
    bit         m_q[$];
    bit         m_level;
    int         m_run;
    bit         m_go;
    logic [7:0] m_count;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
        m_level = 1'b0;
        m_run   = 0;
        m_go    = 1'b0;
        m_count = 8'd0;
        last_go = -1;
    endtask

    task automatic model_edge(input logic pin);
        bit s;
        s = m_q.pop_front();
        m_q.push_back(pin != 1'(ALOW));
        if (m_go) begin
            m_go    = 1'b0;
            m_count = m_count + 8'd1;
        end else if (s == m_level) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = s;
                m_run   = 0;
                m_go    = s;
            end
        end
    endtask

    // One clock: advance the model at the edge, compare #1 later.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset_n) model_reset();
        else model_edge(btn_raw);
        #1;
        check("go", go, m_go);
        check("btn_level", btn_level, m_level);
        check("press_count", press_count, m_count);
        if (go === 1'b1) begin
            go_seen++;
            if (last_go >= 0) check("go_gap_ok", (cyc - last_go) >= GAP_MIN, 1);
            last_go = cyc;
        end
    endtask

    task automatic assert_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_go", go, 0);
        check("rst_level", btn_level, 0);
        check("rst_count", press_count, 0);
        check("rst_state", dbg_state, IDLE);
        repeat (cycles) tick();
        reset_n = 1'b1;
    endtask

    task automatic drive_run(input logic v, input int n);
        btn_raw = v;
        repeat (n) tick();
    endtask

    task automatic press_release(input int plen, input int rlen, output int gos);
        int g0;
        g0 = go_seen;
        drive_run(1'b0, plen);
        drive_run(1'b1, rlen);
        gos = go_seen - g0;
    endtask

    // ---------------- downstream write-enable FSM stand-in ----------------
    int we_st = 0;
    int we_log[$];
    always @(posedge clk) begin
        if (!reset_n) we_st = 0;
        else if (go === 1'b1 && we_st < 4) begin
            we_st = we_st + 1;
            we_log.push_back(we_st);
        end
    end

    // ---------------- directed table (clean press from idle) ----------------
    typedef struct {
        logic       pin;
        logic       exp_go;
        logic       exp_level;
        logic [7:0] exp_count;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int base;
        int g0;
        int gos;
        int go_at;

        for (int i = 0; i < 10; i++) begin
            tbl[i].pin       = 1'b0;
            tbl[i].exp_go    = (i == SYNC + D);
            tbl[i].exp_level = (i >= SYNC + D);
            tbl[i].exp_count = (i > SYNC + D) ? 8'd1 : 8'd0;
        end

        btn_raw = 1'b1;
        assert_reset(3);
        drive_run(1'b1, 4);

        // 1: clean press, table-driven
        for (int i = 0; i < 10; i++) begin
            btn_raw = tbl[i].pin;
            tick();
            check("tbl_go", go, tbl[i].exp_go);
            check("tbl_level", btn_level, tbl[i].exp_level);
            check("tbl_count", press_count, tbl[i].exp_count);
        end

        // 3: release bounce from HELD: high 2, low 1, then high
        g0 = go_seen;
        for (int i = 0; i < 12; i++) begin
            btn_raw = (i == 2) ? 1'b0 : 1'b1;
            tick();
            check("relb_level", btn_level, (i < 9) ? 1 : 0);
        end
        check("relb_no_go", go_seen - g0, 0);

        // 2: press bounce: low 3, high 1, then low stable
        g0 = go_seen;
        go_at = -1;
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            btn_raw = (i == 3) ? 1'b1 : 1'b0;
            tick();
            if (go === 1'b1) go_at = cyc - base;
        end
        check("pb_go_count", go_seen - g0, 1);
        check("pb_latency", go_at, 4 + SYNC + D + 1);
        check("pb_count", press_count, 2);
        drive_run(1'b1, 10);

        // 5: reset mid-ARM with the button held through reset
        btn_raw = 1'b0;
        repeat (5) tick();
        check("marm_state", dbg_state, ARM);
        assert_reset(3);
        g0 = go_seen;
        go_at = -1;
        base = cyc;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (go === 1'b1) go_at = cyc - base;
        end
        check("marm_go_count", go_seen - g0, 1);
        check("marm_latency", go_at, SYNC + D + 1);
        drive_run(1'b1, 10);

        // 4: 256 press/release pairs, counter wraps
        assert_reset(2);
        drive_run(1'b1, 3);
        g0 = go_seen;
        for (int k = 0; k < 256; k++) begin
            press_release($urandom_range(6, 10), $urandom_range(6, 10), gos);
            if (gos != 1) check("b2b_single", gos, 1);
            if (k == 254) check("b2b_count255", press_count, 255);
        end
        check("b2b_total", go_seen - g0, 256);
        check("b2b_wrap", press_count, 0);

        // random bouncy activity against the model
        for (int r = 0; r < 300; r++) begin
            drive_run(1'($urandom_range(0, 1)), $urandom_range(1, 8));
        end
        drive_run(1'b1, 10);

        // 6: integration with the write-enable FSM
        assert_reset(2);
        we_log.delete();
        drive_run(1'b1, 3);
        for (int k = 0; k < 4; k++) press_release(8, 8, gos);
        check("we_log_size", we_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < we_log.size()) check("we_order", we_log[k], k + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
